// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the hazard scoreboard
package hazard_pkg;

    localparam int HZ_STAGES = 3;
    localparam int AGE_W     = $clog2(HZ_STAGES + 2);

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_EX   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_WB   = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic [AGE_W-1:0] age;
        logic [AGE_W-1:0] rdy_age;
    } sb_entry_t;

    // Age of an in-flight write maps directly onto the stage holding it.
    function automatic fwd_sel_t age_to_fwd(input logic [AGE_W-1:0] age);
        case (age)
            AGE_W'(1): age_to_fwd = FWD_EX;
            AGE_W'(2): age_to_fwd = FWD_MEM;
            AGE_W'(3): age_to_fwd = FWD_WB;
            default:   age_to_fwd = FWD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// rtl/hazard_scoreboard_sb_entry.sv - age tracker for one architectural register
module sb_entry
    import hazard_pkg::*;
#(
    parameter int STAGES   = HZ_STAGES,
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 3
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     alloc,
    input  logic     alloc_load,
    output logic     busy,
    output fwd_sel_t fwd
);

    sb_entry_t ent;

    // Allocation beats aging/retire so the youngest writer always owns the entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ent <= '0;
        end else if (alloc) begin
            ent.valid   <= 1'b1;
            ent.age     <= AGE_W'(1);
            ent.rdy_age <= alloc_load ? AGE_W'(LOAD_LAT) : AGE_W'(ALU_LAT);
        end else if (ent.valid) begin
            if (ent.age == AGE_W'(STAGES)) begin
                ent.valid <= 1'b0;
                ent.age   <= '0;
            end else begin
                ent.age <= ent.age + AGE_W'(1);
            end
        end
    end

    // Not-ready writers request a stall; ready ones forward from their stage.
    always_comb begin
        busy = ent.valid && (ent.age < ent.rdy_age);
        fwd  = FWD_NONE;
        if (ent.valid && !busy) begin
            fwd = age_to_fwd(ent.age);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode-side stall, flush and forwarding controller
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = 5,
    parameter int STAGES       = HZ_STAGES,
    parameter int ALU_LAT      = 1,
    parameter int LOAD_LAT     = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ISSUE_VALID,
    input  logic [ADDR_W-1:0] D_RS1,
    input  logic [ADDR_W-1:0] D_RS2,
    input  logic              D_USE_RS1,
    input  logic              D_USE_RS2,
    input  logic [ADDR_W-1:0] D_WADDR,
    input  logic              D_REG_WRITE,
    input  logic              D_IS_LOAD,
    input  logic              REDIRECT,
    output logic              ISSUE_FIRE,
    output logic              STALL,
    output logic              FLUSH,
    output logic [1:0]        FWD_RS1,
    output logic [1:0]        FWD_RS2,
    output logic [CNT_W-1:0]  STALL_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    localparam int NSLOT = 2 ** ADDR_W;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    logic     busy_v [NSLOT];
    fwd_sel_t fwd_v  [NSLOT];
    logic     alloc_en;
    logic     src_wait;
    logic [FC_W-1:0] flush_cnt;

    assign alloc_en = ISSUE_FIRE && D_REG_WRITE;

    // x0 and addresses beyond NUM_REGS are never tracked and always read the RF.
    for (genvar r = 0; r < NSLOT; r++) begin : g_slot
        if (r >= 1 && r < NUM_REGS) begin : g_trk
            sb_entry #(
                .STAGES   (STAGES),
                .ALU_LAT  (ALU_LAT),
                .LOAD_LAT (LOAD_LAT)
            ) u_entry (
                .CLK        (CLK),
                .RST        (RST),
                .alloc      (alloc_en && (D_WADDR == ADDR_W'(r))),
                .alloc_load (D_IS_LOAD),
                .busy       (busy_v[r]),
                .fwd        (fwd_v[r])
            );
        end else begin : g_none
            assign busy_v[r] = 1'b0;
            assign fwd_v[r]  = FWD_NONE;
        end
    end

    // Same-cycle decisions from pre-update scoreboard state; flush outranks stall.
    always_comb begin
        FLUSH      = !RST && (REDIRECT || (flush_cnt != '0));
        src_wait   = (D_USE_RS1 && busy_v[D_RS1]) || (D_USE_RS2 && busy_v[D_RS2]);
        STALL      = !RST && ISSUE_VALID && src_wait && !FLUSH;
        ISSUE_FIRE = !RST && ISSUE_VALID && !STALL && !FLUSH;
        FWD_RS1    = D_USE_RS1 ? fwd_v[D_RS1] : FWD_NONE;
        FWD_RS2    = D_USE_RS2 ? fwd_v[D_RS2] : FWD_NONE;
    end

    // Redirect (re)loads the hold counter; it otherwise drains to zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flush_cnt <= '0;
        end else if (REDIRECT) begin
            flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
        end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - FC_W'(1);
        end
    end

    // Saturating performance counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            STALL_CNT <= '0;
            FLUSH_CNT <= '0;
        end else begin
            if (STALL && (STALL_CNT != '1)) begin
                STALL_CNT <= STALL_CNT + CNT_W'(1);
            end
            if (REDIRECT && (FLUSH_CNT != '1)) begin
                FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - randomized self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    localparam int STAGES       = 3;
    localparam int ALU_LAT      = 1;
    localparam int LOAD_LAT     = 3;
    localparam int FLUSH_CYCLES = 2;

    logic        CLK;
    logic        RST;
    logic        ISSUE_VALID;
    logic [4:0]  D_RS1, D_RS2, D_WADDR;
    logic        D_USE_RS1, D_USE_RS2, D_REG_WRITE, D_IS_LOAD, REDIRECT;
    logic        ISSUE_FIRE, STALL, FLUSH;
    logic [1:0]  FWD_RS1, FWD_RS2;
    logic [31:0] STALL_CNT, FLUSH_CNT;

    hazard_scoreboard #(
        .NUM_REGS(32), .ADDR_W(5), .STAGES(STAGES), .ALU_LAT(ALU_LAT),
        .LOAD_LAT(LOAD_LAT), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(32)
    ) dut (
        .CLK(CLK), .RST(RST), .ISSUE_VALID(ISSUE_VALID),
        .D_RS1(D_RS1), .D_RS2(D_RS2), .D_USE_RS1(D_USE_RS1), .D_USE_RS2(D_USE_RS2),
        .D_WADDR(D_WADDR), .D_REG_WRITE(D_REG_WRITE), .D_IS_LOAD(D_IS_LOAD),
        .REDIRECT(REDIRECT), .ISSUE_FIRE(ISSUE_FIRE), .STALL(STALL), .FLUSH(FLUSH),
        .FWD_RS1(FWD_RS1), .FWD_RS2(FWD_RS2), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference: each register remembers the cycle its latest writer issued.
    bit wv   [32];
    int wcyc [32];
    int wlat [32];
    int cyc;
    int flush_end;
    int m_stall_cnt, m_flush_cnt;

    int n_total, n_pass;
    logic       last_stall, last_fire, last_flush;
    logic [1:0] last_fwd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic int m_age(input int r);
        int a;
        if (r == 0 || !wv[r]) return 0;
        a = cyc - wcyc[r];
        return (a >= 1 && a <= STAGES) ? a : 0;
    endfunction

    function automatic bit m_busy(input int r, input bit use_it);
        int a;
        a = m_age(r);
        return use_it && a != 0 && a < wlat[r];
    endfunction

    function automatic int m_fwd(input int r, input bit use_it);
        int a;
        a = m_age(r);
        return (use_it && a != 0 && a >= wlat[r]) ? a : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) wv[i] = 1'b0;
        flush_end   = -1;
        m_stall_cnt = 0;
        m_flush_cnt = 0;
    endtask

    task automatic step(input bit iv, input int rs1, input int rs2, input bit u1, input bit u2,
                        input int rd, input bit rw, input bit ld, input bit rdr);
        bit e_flush, e_stall, e_fire;
        ISSUE_VALID = iv;  D_RS1 = 5'(rs1); D_RS2 = 5'(rs2);
        D_USE_RS1 = u1;    D_USE_RS2 = u2;  D_WADDR = 5'(rd);
        D_REG_WRITE = rw;  D_IS_LOAD = ld;  REDIRECT = rdr;
        #1;
        e_flush = rdr || (cyc <= flush_end);
        e_stall = iv && (m_busy(rs1, u1) || m_busy(rs2, u2)) && !e_flush;
        e_fire  = iv && !e_stall && !e_flush;
        check("flush", 32'(FLUSH), 32'(e_flush));
        check("stall", 32'(STALL), 32'(e_stall));
        check("fire", 32'(ISSUE_FIRE), 32'(e_fire));
        check("fwd_rs1", 32'(FWD_RS1), 32'(m_fwd(rs1, u1)));
        check("fwd_rs2", 32'(FWD_RS2), 32'(m_fwd(rs2, u2)));
        check("stall_cnt", STALL_CNT, 32'(m_stall_cnt));
        check("flush_cnt", FLUSH_CNT, 32'(m_flush_cnt));
        last_stall = STALL; last_fire = ISSUE_FIRE; last_flush = FLUSH; last_fwd1 = FWD_RS1;
        @(posedge CLK);
        if (e_fire && rw && rd != 0) begin
            wv[rd] = 1'b1; wcyc[rd] = cyc; wlat[rd] = ld ? LOAD_LAT : ALU_LAT;
        end
        if (e_stall) m_stall_cnt++;
        if (rdr) begin
            m_flush_cnt++;
            flush_end = cyc + FLUSH_CYCLES - 1;
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    int nst, cnt0, nfl;
    int exp_seq [4] = '{1, 2, 3, 0};

    initial begin
        n_total = 0; n_pass = 0; cyc = 0;
        model_reset();
        RST = 1'b1; ISSUE_VALID = 1'b1; D_RS1 = 5'd0; D_RS2 = 5'd0; D_WADDR = 5'd0;
        D_USE_RS1 = 1'b0; D_USE_RS2 = 1'b0; D_REG_WRITE = 1'b0; D_IS_LOAD = 1'b0; REDIRECT = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_stall", 32'(STALL), 0);
        check("rst_flush", 32'(FLUSH), 0);
        check("rst_fire", 32'(ISSUE_FIRE), 0);
        check("rst_fwd", 32'({FWD_RS1, FWD_RS2}), 0);
        check("rst_cnts", STALL_CNT | FLUSH_CNT, 0);
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); #1;

        // ALU producer followed by four back-to-back consumers
        step(1, 0, 0, 0, 0, 5, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 5, 0, 1, 0, 10, 1, 0, 0);
            check("alu_chain_stall", 32'(last_stall), 0);
            check("alu_chain_fwd", 32'(last_fwd1), 32'(exp_seq[i]));
        end
        idle(4);

        // load-use: two stall cycles then issue from WB
        cnt0 = STALL_CNT;
        step(1, 0, 0, 0, 0, 6, 1, 1, 0);
        nst = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 6, 0, 1, 0, 7, 1, 0, 0);
            if (last_stall) nst++;
            if (last_fire) break;
        end
        check("lu_stall_cycles", 32'(nst), 2);
        check("lu_fwd", 32'(last_fwd1), 3);
        check("lu_stall_cnt", STALL_CNT - 32'(cnt0), 2);
        idle(4);

        // writes to x0 never allocate
        step(1, 0, 0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 1, 1, 1, 0, 0);
        check("x0_stall", 32'(last_stall), 0);
        idle(4);

        // WAW: younger ALU write hides the older load
        step(1, 0, 0, 0, 0, 8, 1, 1, 0);
        step(1, 0, 0, 0, 0, 8, 1, 0, 0);
        step(1, 8, 0, 1, 0, 9, 1, 0, 0);
        check("waw_stall", 32'(last_stall), 0);
        check("waw_fwd", 32'(last_fwd1), 1);
        idle(4);

        // single redirect, then a redirect restarting the flush
        nfl = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 1); nfl += last_flush;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0); nfl += last_flush;
        end
        check("flush_len1", 32'(nfl), 2);
        cnt0 = FLUSH_CNT; nfl = 0;
        step(1, 0, 0, 0, 0, 0, 0, 0, 1); nfl += last_flush;
        step(1, 0, 0, 0, 0, 0, 0, 0, 1); nfl += last_flush;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, 0); nfl += last_flush;
        end
        check("flush_len2", 32'(nfl), 3);
        check("flush_cnt_delta", FLUSH_CNT - 32'(cnt0), 2);
        idle(4);

        // asynchronous reset in the middle of a load-use stall
        step(1, 0, 0, 0, 0, 6, 1, 1, 0);
        step(1, 6, 0, 1, 0, 7, 1, 0, 0);
        check("pre_rst_stall", 32'(last_stall), 1);
        RST = 1'b1;
        #1;
        check("arst_stall", 32'(STALL), 0);
        check("arst_fwd", 32'(FWD_RS1), 0);
        check("arst_fire", 32'(ISSUE_FIRE), 0);
        check("arst_cnt", STALL_CNT, 0);
        model_reset();
        @(negedge CLK); RST = 1'b0;
        @(posedge CLK); cyc++; #1;
        step(1, 6, 0, 1, 0, 7, 1, 0, 0);
        check("post_rst_fwd", 32'(last_fwd1), 0);
        check("post_rst_stall", 32'(last_stall), 0);

        // randomized traffic over a small register window
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
